// File: rtl/kt_tour_checker.sv
// Knight's-tour stream checker: validates one tour per session and reports
// pass/fail, the first failing step and the visited-square map.
module kt_tour_checker #(
  parameter int unsigned BOARD = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [2:0]  in_x,
  input  logic [2:0]  in_y,
  input  logic [4:0]  in_move,
  output logic        out_valid,
  output logic        pass,
  output logic [2:0]  err_code,
  output logic [4:0]  err_step,
  output logic [24:0] visited,
  output logic [7:0]  tour_cnt
);

  localparam logic [4:0] TOTAL = 5'(BOARD * BOARD);

  typedef enum logic [1:0] {IDLE, RECV, REPORT, DRAIN} state_t;
  typedef enum logic [2:0] {
    E_OK = 3'd0, E_RANGE = 3'd1, E_SEQ = 3'd2,
    E_REVISIT = 3'd3, E_NOT_KNIGHT = 3'd4, E_GAP = 3'd5
  } err_t;

  state_t      state_q, state_d;
  logic [4:0]  step_q, step_d;
  err_t        err_q, err_d;
  logic [4:0]  err_at_q, err_at_d;
  logic [2:0]  prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [24:0] visited_q, visited_d;
  logic        out_valid_q, out_valid_d;
  logic        pass_q, pass_d;
  logic [2:0]  code_q, code_d;
  logic [4:0]  step_out_q, step_out_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [4:0]  cur_step;
  logic [24:0] vis_base, sq_bit;
  logic [4:0]  sq_idx;
  logic        in_range, is_knight, report;
  logic [3:0]  dx, dy, adx, ady;
  err_t        sample_err;

  // Classify the current sample against the running session state.
  always_comb begin
    cur_step   = (state_q == IDLE) ? 5'd1 :
                 ((step_q == TOTAL) ? TOTAL : step_q + 5'd1);
    vis_base   = (state_q == IDLE) ? '0 : visited_q;
    in_range   = (32'(in_x) < BOARD) && (32'(in_y) < BOARD);
    sq_idx     = 5'(32'(in_y) * BOARD + 32'(in_x));
    sq_bit     = in_range ? (25'd1 << sq_idx) : '0;
    dx         = {1'b0, in_x} - {1'b0, prev_x_q};
    dy         = {1'b0, in_y} - {1'b0, prev_y_q};
    adx        = dx[3] ? (4'd0 - dx) : dx;
    ady        = dy[3] ? (4'd0 - dy) : dy;
    is_knight  = ((adx == 4'd1) && (ady == 4'd2)) || ((adx == 4'd2) && (ady == 4'd1));
    sample_err = E_OK;
    if (!in_range)                             sample_err = E_RANGE;
    else if (in_move != cur_step)              sample_err = E_SEQ;
    else if ((vis_base & sq_bit) != '0)        sample_err = E_REVISIT;
    else if ((cur_step > 5'd1) && !is_knight)  sample_err = E_NOT_KNIGHT;
  end

  // Session FSM: next state, error latch and report generation.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    err_d       = err_q;
    err_at_d    = err_at_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    visited_d   = visited_q;
    out_valid_d = 1'b0;
    pass_d      = 1'b0;
    code_d      = '0;
    step_out_d  = '0;
    cnt_d       = cnt_q;
    report      = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d   = RECV;
        step_d    = 5'd1;
        err_d     = sample_err;
        err_at_d  = (sample_err != E_OK) ? 5'd1 : 5'd0;
        prev_x_d  = in_x;
        prev_y_d  = in_y;
        visited_d = vis_base | sq_bit;
      end
      RECV: if (in_valid) begin
        step_d = cur_step;
        if ((err_q == E_OK) && (sample_err != E_OK)) begin
          err_d    = sample_err;
          err_at_d = cur_step;
        end
        prev_x_d  = in_x;
        prev_y_d  = in_y;
        visited_d = visited_q | sq_bit;
        if (cur_step == TOTAL) begin
          state_d = REPORT;
          report  = 1'b1;
        end
      end else begin
        if (err_q == E_OK) begin
          err_d    = E_GAP;
          err_at_d = step_q + 5'd1;
        end
        state_d = REPORT;
        report  = 1'b1;
      end
      REPORT: state_d = in_valid ? DRAIN : IDLE;
      DRAIN:  if (!in_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Result fields are registered on entry to REPORT so they include the final sample.
    if (report) begin
      out_valid_d = 1'b1;
      pass_d      = (err_d == E_OK);
      code_d      = err_d;
      step_out_d  = err_at_d;
      cnt_d       = cnt_q + 8'd1;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      err_q       <= E_OK;
      err_at_q    <= '0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
      visited_q   <= '0;
      out_valid_q <= 1'b0;
      pass_q      <= 1'b0;
      code_q      <= '0;
      step_out_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      err_q       <= err_d;
      err_at_q    <= err_at_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      visited_q   <= visited_d;
      out_valid_q <= out_valid_d;
      pass_q      <= pass_d;
      code_q      <= code_d;
      step_out_q  <= step_out_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pass      = pass_q;
  assign err_code  = code_q;
  assign err_step  = step_out_q;
  assign visited   = visited_q;
  assign tour_cnt  = cnt_q;

endmodule

// File: tb/tb_kt_tour_checker.sv
// Bench for kt_tour_checker: drives tour sessions and compares each report
// against a reference computed from the knight-tour rules.
module tb_kt_tour_checker;
  localparam int B = 5;
  localparam int T = B * B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_x, in_y;
  logic [4:0]  in_move;
  logic        out_valid, pass;
  logic [2:0]  err_code;
  logic [4:0]  err_step;
  logic [24:0] visited;
  logic [7:0]  tour_cnt;

  always #5 clk = ~clk;

  kt_tour_checker #(.BOARD(B)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_move(in_move), .out_valid(out_valid), .pass(pass), .err_code(err_code),
    .err_step(err_step), .visited(visited), .tour_cnt(tour_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int sx[40], sy[40], sm[40];
  int n_s;
  int tour_x[25], tour_y[25];
  // Move number of each square of a known 5x5 tour, row-major from (0,0).
  int grid[25] = '{1, 14, 9, 20, 3,  24, 19, 2, 15, 10,  13, 8, 25, 4, 21,
                   18, 23, 6, 11, 16,  7, 12, 17, 22, 5};
  int          exp_code, exp_step;
  logic [24:0] exp_vis;
  logic [7:0]  exp_cnt = 8'd0;

  task automatic build_tour();
    for (int i = 0; i < T; i++) begin
      tour_x[grid[i] - 1] = i % B;
      tour_y[grid[i] - 1] = i / B;
    end
  endtask

  // Load the known tour under one of the 8 board symmetries (still a legal tour).
  task automatic load_tour(input int sym);
    int x, y, t;
    for (int i = 0; i < T; i++) begin
      x = tour_x[i]; y = tour_y[i];
      if (sym[0]) begin t = x; x = y; y = t; end
      if (sym[1]) x = B - 1 - x;
      if (sym[2]) y = B - 1 - y;
      sx[i] = x; sy[i] = y; sm[i] = i + 1;
    end
    n_s = T;
  endtask

  // Reference: walk the samples applying the rules in priority order.
  task automatic model();
    bit seen[25];
    int lim, px, py, x, y, c, ax, ay;
    bit inr;
    for (int i = 0; i < 25; i++) seen[i] = 0;
    exp_code = 0; exp_step = 0; px = 0; py = 0;
    lim = (n_s < T) ? n_s : T;
    for (int s = 1; s <= lim; s++) begin
      x = sx[s-1]; y = sy[s-1];
      inr = (x < B) && (y < B);
      ax = (x > px) ? x - px : px - x;
      ay = (y > py) ? y - py : py - y;
      c = 0;
      if (!inr) c = 1;
      else if (sm[s-1] != s) c = 2;
      else if (seen[y*B+x]) c = 3;
      else if (s > 1 && !((ax == 1 && ay == 2) || (ax == 2 && ay == 1))) c = 4;
      if (exp_code == 0 && c != 0) begin exp_code = c; exp_step = s; end
      if (inr) seen[y*B+x] = 1;
      px = x; py = y;
    end
    if (lim < T && exp_code == 0) begin exp_code = 5; exp_step = lim + 1; end
    exp_vis = '0;
    for (int i = 0; i < 25; i++) exp_vis[i] = seen[i];
  endtask

  // Stream the loaded samples back-to-back, then in_valid=0; check the single report.
  // Entered and left #1 after a rising edge.
  task automatic run_session(input string name);
    int rep_t, last_t;
    model();
    exp_cnt = exp_cnt + 8'd1;
    rep_t  = (n_s >= T) ? T : n_s + 1;
    last_t = ((n_s > rep_t) ? n_s : rep_t) + 1;
    for (int t = 0; t <= last_t; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== (t == rep_t)) begin
          n_fail++;
          $display("FAIL %s out_valid cyc%0d: got %b want %b", name, t, out_valid, (t == rep_t));
        end
        if (t == rep_t) begin
          n_tests += 5;
          if (pass !== (exp_code == 0)) begin
            n_fail++; $display("FAIL %s pass: got %b want %b", name, pass, (exp_code == 0));
          end
          if (err_code !== 3'(exp_code)) begin
            n_fail++; $display("FAIL %s err_code: got %0d want %0d", name, err_code, exp_code);
          end
          if (err_step !== 5'(exp_step)) begin
            n_fail++; $display("FAIL %s err_step: got %0d want %0d", name, err_step, exp_step);
          end
          if (visited !== exp_vis) begin
            n_fail++; $display("FAIL %s visited: got %h want %h", name, visited, exp_vis);
          end
          if (tour_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL %s tour_cnt: got %0d want %0d", name, tour_cnt, exp_cnt);
          end
        end
        if (t == last_t) begin
          n_tests += 2;
          if ({pass, err_code, err_step} !== 9'd0) begin
            n_fail++;
            $display("FAIL %s fields_clear: got pass=%b code=%0d step=%0d want 0", name, pass, err_code, err_step);
          end
          if (visited !== exp_vis) begin
            n_fail++; $display("FAIL %s visited_hold: got %h want %h", name, visited, exp_vis);
          end
        end
      end
      if (t < n_s) begin
        in_valid = 1'b1; in_x = 3'(sx[t]); in_y = 3'(sy[t]); in_move = 5'(sm[t]);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_move = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, pass, err_code, err_step, visited, tour_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset: got ov=%b pass=%b code=%0d step=%0d vis=%h cnt=%0d want all 0",
               out_valid, pass, err_code, err_step, visited, tour_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_legal_tour();
    load_tour(0); run_session("legal_tour");
  endtask

  task automatic test_not_knight();
    load_tour(0); sx[1] = 1; sy[1] = 1; run_session("not_knight");
  endtask

  task automatic test_revisit();
    load_tour(0); sx[4] = sx[2]; sy[4] = sy[2]; run_session("revisit");
  endtask

  task automatic test_gap();
    load_tour(0); n_s = 10; run_session("gap");
  endtask

  task automatic test_range_seq();
    load_tour(0); sx[0] = 5; sy[0] = 0; sm[0] = 2; run_session("range_beats_seq");
  endtask

  task automatic test_drain();
    load_tour(0);
    for (int i = T; i < 30; i++) begin
      sx[i] = $urandom % B; sy[i] = $urandom % B; sm[i] = i + 1;
    end
    n_s = 30;
    run_session("drain");
  endtask

  task automatic test_back_to_back();
    load_tour(int'($urandom % 8)); run_session("b2b_a");
    load_tour(int'($urandom % 8)); run_session("b2b_b");
  endtask

  task automatic test_abort();
    load_tour(0);
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_x = 3'(sx[i]); in_y = 3'(sy[i]); in_move = 5'(sm[i]);
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL abort_stream out_valid: got %b want 0", out_valid);
      end
    end
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, visited, tour_cnt} !== '0) begin
      n_fail++;
      $display("FAIL abort_clear: got ov=%b vis=%h cnt=%0d want 0", out_valid, visited, tour_cnt);
    end
    exp_cnt = 8'd0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_report: got %b want 0", out_valid);
    end
    load_tour(int'($urandom % 8)); run_session("after_abort");
  endtask

  task automatic test_random();
    int mode, k;
    for (int it = 0; it < 24; it++) begin
      load_tour(int'($urandom % 8));
      mode = int'($urandom % 4);
      k = int'($urandom % T);
      case (mode)
        0: begin
          n_s = T + int'($urandom % 6);
          for (int i = T; i < n_s; i++) begin
            sx[i] = $urandom % 8; sy[i] = $urandom % 8; sm[i] = $urandom % 32;
          end
        end
        1: begin sx[k] = $urandom % 8; sy[k] = $urandom % 8; end
        2: sm[k] = $urandom % 32;
        default: n_s = 1 + int'($urandom % (T - 1));
      endcase
      run_session("random");
    end
  endtask

  task automatic test_cnt_wrap();
    for (int i = 0; i < 256; i++) begin
      n_s = 1; sx[0] = $urandom % B; sy[0] = $urandom % B; sm[0] = 1;
      run_session("cnt_wrap");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tour();
    test_reset();
    test_legal_tour();
    test_not_knight();
    test_revisit();
    test_gap();
    test_range_seq();
    test_drain();
    test_back_to_back();
    test_abort();
    test_random();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
